// File: rtl/rv64_pipe_pkg.sv
// Shared definitions for the RV64 5-stage pipeline control slice.
//   state_e      : hazard controller FSM states
//   stg_ctl_t    : {en, clr} pair driving one dff_enrc stage register
//   PC_SEL_*     : PC source select encodings
//   FWD_*        : operand forwarding select encodings
//   RW, CNT_W    : register address width, controller counter width
//   fwd_pick()   : forwarding priority helper (EX/MEM over MEM/WB)
package rv64_pipe_pkg;

  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MD_BUSY    = 2'd1,
    ST_TRAP_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_EX   = 2'b01;
  localparam logic [1:0] PC_SEL_TRAP = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic en;
    logic clr;
  } stg_ctl_t;

  // en=1,clr=0 loads d; en=0 holds; en=1,clr=1 loads a bubble
  localparam stg_ctl_t STG_RUN    = '{en: 1'b1, clr: 1'b0};
  localparam stg_ctl_t STG_HOLD   = '{en: 1'b0, clr: 1'b0};
  localparam stg_ctl_t STG_BUBBLE = '{en: 1'b1, clr: 1'b1};

  // A load in EX cannot supply its result yet, so it falls through to MEM/WB
  function automatic logic [1:0] fwd_pick(input logic ex_hit,
                                          input logic ex_load,
                                          input logic mem_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_hit && !ex_load) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rv64_fwd_unit.sv
// Combinational source/destination register compare for the ID stage.
// Configuration macro: HAZ_FORWARD_EN
//   defined   : forwarding selects from EX/MEM and MEM/WB; raw_hit flags load-use only
//   undefined : no forwarding; raw_hit flags any used source matching a writing EX/MEM rd
// Ports:
//   rs1, rs2        in  RW  ID source registers
//   use1, use2      in  1   ID actually reads rs1/rs2
//   ex_rd, ex_wen, ex_load  in  EX destination, write enable, load flag
//   mem_rd, mem_wen in      MEM destination, write enable
//   fwd_a, fwd_b    out 2   forwarding selects for the operands latched into ID/EX
//   raw_hit         out 1   ID must stall one cycle
module rv64_fwd_unit #(
  parameter int unsigned RW = rv64_pipe_pkg::RW
) (
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic          use1,
  input  logic          use2,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_wen,
  input  logic          ex_load,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_wen,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          raw_hit
);
  import rv64_pipe_pkg::*;

  logic ex_hit1;
  logic ex_hit2;
  logic mem_hit1;
  logic mem_hit2;

  // x0 is never a producer
  assign ex_hit1  = ex_wen  && (ex_rd  != '0) && (ex_rd  == rs1);
  assign ex_hit2  = ex_wen  && (ex_rd  != '0) && (ex_rd  == rs2);
  assign mem_hit1 = mem_wen && (mem_rd != '0) && (mem_rd == rs1);
  assign mem_hit2 = mem_wen && (mem_rd != '0) && (mem_rd == rs2);

`ifdef HAZ_FORWARD_EN
  assign fwd_a   = fwd_pick(ex_hit1, ex_load, mem_hit1);
  assign fwd_b   = fwd_pick(ex_hit2, ex_load, mem_hit2);
  assign raw_hit = ex_load && ((ex_hit1 && use1) || (ex_hit2 && use2));
`else
  logic unused_ex_load;

  assign fwd_a   = FWD_RF;
  assign fwd_b   = FWD_RF;
  // Repeats every cycle until the producer has left MEM
  assign raw_hit = (use1 && (ex_hit1 || mem_hit1)) ||
                   (use2 && (ex_hit2 || mem_hit2));
  assign unused_ex_load = ex_load;
`endif

endmodule

// File: rtl/rv64_hazard_ctrl.sv
// Pipeline control for the 5-stage RV64 core: stage register en/clr, PC enable,
// PC source select and operand forwarding. Resolves load-use/RAW hazards,
// branch mispredict, multi-cycle MUL/DIV, data-memory wait states and traps.
// Configuration macro: HAZ_FORWARD_EN (see rv64_fwd_unit).
// Parameters: MD_LAT (>=2) cycles a MUL/DIV occupies EX, TRAP_CYC (>=1) drain
//   cycles after a trap redirect, RW register address width.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_rs1/id_rs2, id_use1/id_use2     ID sources and use flags
//   ex_rd, ex_wen, ex_load, ex_md, ex_mispred   EX stage status
//   mem_rd, mem_wen, mem_trap          MEM stage status
//   dmem_stall                         data memory not ready
//   pc_en, pc_sel                      PC enable and source select
//   {ifid,idex,exmem,memwb}_{en,clr}   stage register controls
//   fwd_a, fwd_b                       forwarding selects
//   md_last                            final MUL/DIV cycle, EX result valid
// Outputs are combinational from the FSM state and the current inputs.
module rv64_hazard_ctrl #(
  parameter int unsigned MD_LAT   = 8,
  parameter int unsigned TRAP_CYC = 2,
  parameter int unsigned RW       = rv64_pipe_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_wen,
  input  logic          ex_load,
  input  logic          ex_md,
  input  logic          ex_mispred,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_wen,
  input  logic          mem_trap,
  input  logic          dmem_stall,
  output logic          pc_en,
  output logic [1:0]    pc_sel,
  output logic          ifid_en,
  output logic          ifid_clr,
  output logic          idex_en,
  output logic          idex_clr,
  output logic          exmem_en,
  output logic          exmem_clr,
  output logic          memwb_en,
  output logic          memwb_clr,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          md_last
);
  import rv64_pipe_pkg::*;

  localparam logic [CNT_W-1:0] MD_INIT   = CNT_W'(MD_LAT - 2);
  localparam logic [CNT_W-1:0] TRAP_INIT = CNT_W'(TRAP_CYC - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             md_ack_q;
  logic             md_ack_d;
  logic             raw_hit;
  logic             run_haz;
  stg_ctl_t         ifid_c;
  stg_ctl_t         idex_c;
  stg_ctl_t         exmem_c;
  stg_ctl_t         memwb_c;

  // Register compare / forwarding
  rv64_fwd_unit #(
    .RW (RW)
  ) u_fwd (
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use1    (id_use1),
    .use2    (id_use2),
    .ex_rd   (ex_rd),
    .ex_wen  (ex_wen),
    .ex_load (ex_load),
    .mem_rd  (mem_rd),
    .mem_wen (mem_wen),
    .fwd_a   (fwd_a),
    .fwd_b   (fwd_b),
    .raw_hit (raw_hit)
  );

  // Next state and stage control, highest priority event first
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_ack_d = md_ack_q;
    pc_en    = 1'b1;
    pc_sel   = PC_SEL_SEQ;
    ifid_c   = STG_RUN;
    idex_c   = STG_RUN;
    exmem_c  = STG_RUN;
    memwb_c  = STG_RUN;
    md_last  = 1'b0;
    run_haz  = 1'b0;

    if (mem_trap) begin
      // Flush everything and abort any MUL/DIV in flight
      pc_sel   = PC_SEL_TRAP;
      ifid_c   = STG_BUBBLE;
      idex_c   = STG_BUBBLE;
      exmem_c  = STG_BUBBLE;
      memwb_c  = STG_BUBBLE;
      state_d  = ST_TRAP_DRAIN;
      cnt_d    = TRAP_INIT;
      md_ack_d = 1'b0;
    end else if (dmem_stall) begin
      // MEM cannot complete: freeze upstream, bubble into WB, counters hold
      pc_en   = 1'b0;
      ifid_c  = STG_HOLD;
      idex_c  = STG_HOLD;
      exmem_c = STG_HOLD;
      memwb_c = STG_BUBBLE;
    end else begin
      unique case (state_q)
        ST_TRAP_DRAIN: begin
          pc_en  = 1'b0;
          ifid_c = STG_BUBBLE;
          idex_c = STG_BUBBLE;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_MD_BUSY: begin
          if (cnt_q == '0) begin
            // Result ready: MUL/DIV leaves EX; ID still subject to its own hazards
            md_last  = 1'b1;
            md_ack_d = 1'b1;
            state_d  = ST_RUN;
            run_haz  = 1'b1;
          end else begin
            pc_en   = 1'b0;
            ifid_c  = STG_HOLD;
            idex_c  = STG_HOLD;
            exmem_c = STG_BUBBLE;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (ex_md && !md_ack_q) begin
            // First MUL/DIV cycle counts towards MD_LAT
            pc_en   = 1'b0;
            ifid_c  = STG_HOLD;
            idex_c  = STG_HOLD;
            exmem_c = STG_BUBBLE;
            state_d = ST_MD_BUSY;
            cnt_d   = MD_INIT;
          end else begin
            run_haz = 1'b1;
          end
        end
      endcase

      if (run_haz) begin
        if (ex_mispred) begin
          // Redirect wins; any load-use stall on the wrong path is moot
          pc_sel = PC_SEL_EX;
          ifid_c = STG_BUBBLE;
          idex_c = STG_BUBBLE;
        end else if (raw_hit) begin
          pc_en  = 1'b0;
          ifid_c = STG_HOLD;
          idex_c = STG_BUBBLE;
        end
      end
    end

    // A new instruction entering EX that is not MUL/DIV re-arms the MUL/DIV start
    if (!mem_trap && !md_last && idex_c.en && !ex_md) begin
      md_ack_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      md_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_ack_q <= md_ack_d;
    end
  end

  assign ifid_en   = ifid_c.en;
  assign ifid_clr  = ifid_c.clr;
  assign idex_en   = idex_c.en;
  assign idex_clr  = idex_c.clr;
  assign exmem_en  = exmem_c.en;
  assign exmem_clr = exmem_c.clr;
  assign memwb_en  = memwb_c.en;
  assign memwb_clr = memwb_c.clr;

endmodule
